// File: rtl/rot_enc_pkg.sv
// ---------------------------------------------------------------------------
// rot_enc_pkg
// Shared definitions for the rotary-encoder front-end:
//   - quadrature state codes, as seen on the debounced {A,B} pair
//   - accumulator width and the count that makes up one full detent
//   - a direction enum plus a helper that classifies a state transition
//   - a counter-width helper used to size the debounce and hold counters
// ---------------------------------------------------------------------------
package rot_enc_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  localparam int ACC_W      = 4;
  localparam int ACC_DETENT = 4;

  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(ACC_DETENT);
  localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_CW      = 2'd1,
    DIR_CCW     = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  // Width needed for a counter that must be able to hold max_val.
  function automatic int cnt_w(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

  // CW order is 00 -> 10 -> 11 -> 01 -> 00 (A leads B). Anything that is
  // neither a CW nor a CCW neighbour is a two-bit jump.
  function automatic dir_e quad_dir(input logic [1:0] prev, input logic [1:0] next);
    dir_e dir;
    dir = DIR_ILLEGAL;
    if (prev == next) begin
      dir = DIR_NONE;
    end else begin
      case (prev)
        QS_00: if (next == QS_10) dir = DIR_CW; else if (next == QS_01) dir = DIR_CCW;
        QS_10: if (next == QS_11) dir = DIR_CW; else if (next == QS_00) dir = DIR_CCW;
        QS_11: if (next == QS_01) dir = DIR_CW; else if (next == QS_10) dir = DIR_CCW;
        default: if (next == QS_00) dir = DIR_CW; else if (next == QS_11) dir = DIR_CCW;
      endcase
    end
    return dir;
  endfunction

endpackage

// File: rtl/rot_enc_ctrl_if.sv
// ---------------------------------------------------------------------------
// rot_enc_ctrl_if
// Pin-side and event-side signals of one rotary encoder.
//   i_enc_a / i_enc_b / i_enc_pb : raw asynchronous encoder pins
//   o_step_up / o_step_dn        : one-cycle detent pulses
//   o_value                      : saturating setting value (VAL_W bits)
//   o_pb_level                   : debounced button level
//   o_pb_press / o_pb_long       : one-cycle button event pulses
// Modports:
//   master : drives the encoder pins and consumes the events
//   slave  : the encoder controller itself
// ---------------------------------------------------------------------------
interface rot_enc_ctrl_if #(
  parameter int VAL_W = 8
);

  logic             i_enc_a;
  logic             i_enc_b;
  logic             i_enc_pb;
  logic             o_step_up;
  logic             o_step_dn;
  logic [VAL_W-1:0] o_value;
  logic             o_pb_level;
  logic             o_pb_press;
  logic             o_pb_long;

  modport master (
    output i_enc_a, i_enc_b, i_enc_pb,
    input  o_step_up, o_step_dn, o_value, o_pb_level, o_pb_press, o_pb_long
  );

  modport slave (
    input  i_enc_a, i_enc_b, i_enc_pb,
    output o_step_up, o_step_dn, o_value, o_pb_level, o_pb_press, o_pb_long
  );

endinterface

// File: rtl/rot_enc_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser followed by a stability debouncer for one raw pin.
// The debounced level only follows the synchronised pin once the pin has
// disagreed with it for DEB_CNT consecutive cycles; any return to agreement
// restarts the count. Pin-to-level latency is 2 + DEB_CNT cycles.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_pin    raw asynchronous pin
//   o_level  debounced level (0 after reset)
// ---------------------------------------------------------------------------
module sw_debounce
  import rot_enc_pkg::*;
#(
  parameter int DEB_CNT = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level
);

  localparam int         CNT_W   = cnt_w(DEB_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d   = i_pin;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_level = stable_q;

endmodule

// File: rtl/rot_enc_ctrl.sv
// ---------------------------------------------------------------------------
// rot_enc_ctrl
// Front-end for one rotary encoder of the stimulator. Debounces the
// A/B/pushbutton pins, decodes full quadrature detents into up/down steps,
// keeps a saturating setting value and generates button events.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      rot_enc_ctrl_if.slave: raw pins in, step/value/button events out
// Configuration:
//   ROT_ENC_LONG_PRESS_EN  when defined, a hold counter detects long presses
//     (o_pb_long pulse, value reloaded to VAL_INIT) and short presses are
//     reported on release; when undefined, o_pb_press fires on the debounced
//     press edge and o_pb_long is tied low.
// ---------------------------------------------------------------------------
module rot_enc_ctrl
  import rot_enc_pkg::*;
#(
  parameter int DEB_CNT  = 1000,
  parameter int VAL_W    = 8,
  parameter int VAL_MIN  = 0,
  parameter int VAL_MAX  = 255,
  parameter int VAL_INIT = 0,
  parameter int STEP     = 1,
  parameter int LONG_CNT = 2000000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rot_enc_ctrl_if.slave  bus
);

  // Value arithmetic runs one bit wider so overflow/underflow is visible.
  localparam logic [VAL_W:0]   STEP_X = (VAL_W + 1)'(STEP);
  localparam logic [VAL_W:0]   MAX_X  = (VAL_W + 1)'(VAL_MAX);
  localparam logic [VAL_W:0]   MIN_X  = (VAL_W + 1)'(VAL_MIN);
  localparam logic [VAL_W-1:0] MAX_V  = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0] MIN_V  = VAL_W'(VAL_MIN);
  localparam logic [VAL_W-1:0] INIT_V = VAL_W'(VAL_INIT);

  logic a_deb, b_deb, pb_deb;

  logic [1:0]              qs_q, qs_d, qs_in;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_next;
  dir_e                    dir;
  logic                    step_up_q, step_up_d;
  logic                    step_dn_q, step_dn_d;

  logic [VAL_W-1:0] value_q, value_d;
  logic [VAL_W:0]   val_x, up_sum, dn_diff;

  logic pb_prev_q, pb_prev_d;
  logic press_q, press_d;

`ifdef ROT_ENC_LONG_PRESS_EN
  localparam int              HOLD_W = cnt_w(LONG_CNT);
  localparam logic [HOLD_W-1:0] LONG_V = HOLD_W'(LONG_CNT);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
`endif

  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (bus.i_enc_a),
    .o_level (a_deb)
  );

  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (bus.i_enc_b),
    .o_level (b_deb)
  );

  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb_pb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (bus.i_enc_pb),
    .o_level (pb_deb)
  );

  // Quadrature decode: the accumulator counts legal quarter-steps since the
  // last detent. A detent only counts when the encoder arrives back at 00 having
  // taken exactly four quarter-steps in one direction; bounce-backs and
  // partial turns leave it short of +/-4 and are dropped on arrival.
  always_comb begin
    qs_in     = {a_deb, b_deb};
    qs_d      = qs_in;
    dir       = quad_dir(qs_q, qs_in);
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    case (dir)
      DIR_CW:      acc_next = acc_q + ACC_ONE;
      DIR_CCW:     acc_next = acc_q - ACC_ONE;
      DIR_ILLEGAL: acc_next = '0;
      default:     acc_next = acc_q;
    endcase
    acc_d = acc_next;
    if ((dir != DIR_NONE) && (qs_in == QS_00)) begin
      if (acc_next == ACC_POS) begin
        step_up_d = 1'b1;
      end else if (acc_next == ACC_NEG) begin
        step_dn_d = 1'b1;
      end
      acc_d = '0;
    end
  end

  // Button events. With long-press support the hold counter decides on
  // release whether the press was short; a press that already reached the
  // long threshold stays silent on release.
  always_comb begin
    pb_prev_d = pb_deb;
`ifdef ROT_ENC_LONG_PRESS_EN
    hold_d = '0;
    if (pb_deb) begin
      hold_d = (hold_q == LONG_V) ? hold_q : hold_q + 1'b1;
    end
    long_d  = (hold_d == LONG_V) && (hold_q != LONG_V);
    press_d = !pb_deb && pb_prev_q && (hold_q < LONG_V);
`else
    press_d = pb_deb && !pb_prev_q;
`endif
  end

  // Saturating setting value, updated in the same cycle the step pulse is
  // registered. A long press reload takes priority over a coincident step.
  always_comb begin
    val_x   = {1'b0, value_q};
    up_sum  = val_x + STEP_X;
    dn_diff = val_x - STEP_X;
    value_d = value_q;
    if (step_up_d) begin
      value_d = (up_sum > MAX_X) ? MAX_V : up_sum[VAL_W-1:0];
    end else if (step_dn_d) begin
      value_d = ((val_x < STEP_X) || (dn_diff < MIN_X)) ? MIN_V : dn_diff[VAL_W-1:0];
    end
`ifdef ROT_ENC_LONG_PRESS_EN
    if (long_d) begin
      value_d = INIT_V;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      qs_q      <= QS_00;
      acc_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      value_q   <= INIT_V;
      pb_prev_q <= 1'b0;
      press_q   <= 1'b0;
`ifdef ROT_ENC_LONG_PRESS_EN
      hold_q    <= '0;
      long_q    <= 1'b0;
`endif
    end else begin
      qs_q      <= qs_d;
      acc_q     <= acc_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      value_q   <= value_d;
      pb_prev_q <= pb_prev_d;
      press_q   <= press_d;
`ifdef ROT_ENC_LONG_PRESS_EN
      hold_q    <= hold_d;
      long_q    <= long_d;
`endif
    end
  end

  assign bus.o_step_up  = step_up_q;
  assign bus.o_step_dn  = step_dn_q;
  assign bus.o_value    = value_q;
  assign bus.o_pb_level = pb_deb;
  assign bus.o_pb_press = press_q;
`ifdef ROT_ENC_LONG_PRESS_EN
  assign bus.o_pb_long  = long_q;
`else
  assign bus.o_pb_long  = 1'b0;
`endif

endmodule

// File: tb/tb_rot_enc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rot_enc_ctrl
// Bench for rot_enc_ctrl. Two instances share the same encoder pins: dut0 starts
// at value 0 (lower saturation) and dut1 at 254 (upper saturation). Directed
// detent sequences come from a table of expected pulse counts and values;
// bounce, reset and button cases are hand-written; a randomized phase is
// checked against a position-based reference model. Honours
// ROT_ENC_LONG_PRESS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rot_enc_ctrl;

  localparam int DEB   = 4;
  localparam int LONGC = 50;

  logic clk;
  logic rst_n;
  logic pin_a, pin_b, pin_pb;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters gathered from the running DUTs.
  int mon_up = 0, mon_dn = 0, mon_press = 0, mon_long = 0, mon_both = 0;

  // Reference model state.
  logic [1:0] m_ab = 2'b00;
  int m_acc = 0, m_up = 0, m_dn = 0, m_press = 0, m_long = 0;
  int m_v0 = 0, m_v1 = 254;

  typedef struct {
    logic [1:0] ab;
    int up;
    int dn;
    int v0;
    int v1;
  } vec_t;
  vec_t vecs[$];

  rot_enc_ctrl_if #(.VAL_W(8)) bus0 ();
  rot_enc_ctrl_if #(.VAL_W(8)) bus1 ();

  assign bus0.i_enc_a  = pin_a;
  assign bus0.i_enc_b  = pin_b;
  assign bus0.i_enc_pb = pin_pb;
  assign bus1.i_enc_a  = pin_a;
  assign bus1.i_enc_b  = pin_b;
  assign bus1.i_enc_pb = pin_pb;

  rot_enc_ctrl #(
    .DEB_CNT(DEB), .VAL_W(8), .VAL_MIN(0), .VAL_MAX(255),
    .VAL_INIT(0), .STEP(1), .LONG_CNT(LONGC)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave)
  );

  rot_enc_ctrl #(
    .DEB_CNT(DEB), .VAL_W(8), .VAL_MIN(0), .VAL_MAX(255),
    .VAL_INIT(254), .STEP(1), .LONG_CNT(LONGC)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every event pulse, sampled half a cycle after the active edge.
  always @(negedge clk) begin
    if (bus0.o_step_up) mon_up++;
    if (bus0.o_step_dn) mon_dn++;
    if (bus0.o_pb_press) mon_press++;
    if (bus0.o_pb_long) mon_long++;
    if (bus0.o_step_up && bus0.o_step_dn) mon_both++;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Position of a quadrature state along the CW cycle 00,10,11,01.
  function automatic int quad_pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sat_add(input int v, input int d);
    int r;
    r = v + d;
    if (r > 255) r = 255;
    if (r < 0) r = 0;
    return r;
  endfunction

  // Model: a detent is four net quarter-steps in one direction ending at 00;
  // a half-turn jump forgets the partial progress.
  function automatic void model_ab(input logic [1:0] nxt);
    int d;
    d = (quad_pos(nxt) - quad_pos(m_ab) + 4) % 4;
    if (d == 1) m_acc = m_acc + 1;
    else if (d == 3) m_acc = m_acc - 1;
    else if (d == 2) m_acc = 0;
    if (d != 0 && nxt == 2'b00) begin
      if (m_acc == 4) begin
        m_up++;
        m_v0 = sat_add(m_v0, 1);
        m_v1 = sat_add(m_v1, 1);
      end else if (m_acc == -4) begin
        m_dn++;
        m_v0 = sat_add(m_v0, -1);
        m_v1 = sat_add(m_v1, -1);
      end
      m_acc = 0;
    end
    m_ab = nxt;
  endfunction

  function automatic void model_press(input int held);
`ifdef ROT_ENC_LONG_PRESS_EN
    if (held >= LONGC) begin
      m_long++;
      m_v0 = 0;
      m_v1 = 254;
    end else begin
      m_press++;
    end
`else
    m_press++;
`endif
  endfunction

  function automatic void model_reset();
    m_ab  = 2'b00;
    m_acc = 0;
    m_v0  = 0;
    m_v1  = 254;
  endfunction

  task automatic apply_stimulus(input logic [1:0] ab, input int hold);
    pin_a = ab[1];
    pin_b = ab[0];
    model_ab(ab);
    wait_cycles(hold);
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " up"}, mon_up, m_up);
    check_output({tag, " dn"}, mon_dn, m_dn);
    check_output({tag, " value0"}, int'(bus0.o_value), m_v0);
    check_output({tag, " value1"}, int'(bus1.o_value), m_v1);
  endtask

  task automatic press_button(input string tag, input int held);
    pin_pb = 1'b1;
    wait_cycles(DEB + 4);
    check_output({tag, " level high"}, int'(bus0.o_pb_level), 1);
    wait_cycles(held - DEB - 4);
    pin_pb = 1'b0;
    model_press(held);
    wait_cycles(DEB + 8);
    check_output({tag, " level low"}, int'(bus0.o_pb_level), 0);
    check_output({tag, " press"}, mon_press, m_press);
    check_output({tag, " long"}, mon_long, m_long);
    check_output({tag, " value0"}, int'(bus0.o_value), m_v0);
    check_output({tag, " value1"}, int'(bus1.o_value), m_v1);
  endtask

  // Appends one full detent; intermediate rows keep the previous totals.
  function automatic void add_turn(input bit cw, input int up, input int dn,
                                   input int v0, input int v1);
    vec_t prev;
    logic [1:0] seq [3];
    if (vecs.size() == 0) prev = '{2'b00, 0, 0, 0, 254};
    else prev = vecs[vecs.size() - 1];
    if (cw) seq = '{2'b10, 2'b11, 2'b01};
    else seq = '{2'b01, 2'b11, 2'b10};
    for (int k = 0; k < 3; k++) vecs.push_back('{seq[k], prev.up, prev.dn, prev.v0, prev.v1});
    vecs.push_back('{2'b00, up, dn, v0, v1});
  endfunction

  initial begin
    int base_up, base_dn, base_press, base_long;
    logic [1:0] order [4];
    logic [1:0] nxt;
    int r, hold, held;

    order = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Expected totals after each row, starting from reset (0 / 254).
    add_turn(1'b1, 1, 0, 1, 255);
    add_turn(1'b1, 2, 0, 2, 255);
    add_turn(1'b1, 3, 0, 3, 255);
    add_turn(1'b0, 3, 1, 2, 254);
    add_turn(1'b0, 3, 2, 1, 253);
    add_turn(1'b0, 3, 3, 0, 252);
    add_turn(1'b0, 3, 4, 0, 251);
    // Partial turn that bounces back to the detent.
    vecs.push_back('{2'b10, 3, 4, 0, 251});
    vecs.push_back('{2'b11, 3, 4, 0, 251});
    vecs.push_back('{2'b10, 3, 4, 0, 251});
    vecs.push_back('{2'b00, 3, 4, 0, 251});
    // Illegal half-turn jumps.
    vecs.push_back('{2'b11, 3, 4, 0, 251});
    vecs.push_back('{2'b00, 3, 4, 0, 251});

    rst_n  = 1'b0;
    pin_a  = 1'b0;
    pin_b  = 1'b0;
    pin_pb = 1'b0;
    wait_cycles(3);
    check_output("reset value0", int'(bus0.o_value), 0);
    check_output("reset value1", int'(bus1.o_value), 254);
    check_output("reset step_up", int'(bus0.o_step_up), 0);
    check_output("reset step_dn", int'(bus0.o_step_dn), 0);
    check_output("reset pb_level", int'(bus0.o_pb_level), 0);
    check_output("reset pb_press", int'(bus0.o_pb_press), 0);
    check_output("reset pb_long", int'(bus0.o_pb_long), 0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Directed detent table.
    base_up = mon_up;
    base_dn = mon_dn;
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].ab, 10);
      check_output($sformatf("vec%0d up", i), mon_up - base_up, vecs[i].up);
      check_output($sformatf("vec%0d dn", i), mon_dn - base_dn, vecs[i].dn);
      check_output($sformatf("vec%0d value0", i), int'(bus0.o_value), vecs[i].v0);
      check_output($sformatf("vec%0d value1", i), int'(bus1.o_value), vecs[i].v1);
    end

    // Bounce on A faster than the debounce window, ending where it started.
    for (int i = 0; i < 10; i++) begin
      pin_a = ~pin_a;
      wait_cycles(2);
    end
    wait_cycles(20);
    check_model("bounce");

    // Button: short press, then a press well beyond the long threshold.
    apply_stimulus(2'b10, 10);
    apply_stimulus(2'b11, 10);
    apply_stimulus(2'b01, 10);
    apply_stimulus(2'b00, 10);
    check_model("pre-button");
    press_button("short press", 10);
    press_button("long press", 80);

    // Reset in the middle of a detent and a press.
    apply_stimulus(2'b10, 10);
    pin_pb = 1'b1;
    wait_cycles(10);
`ifndef ROT_ENC_LONG_PRESS_EN
    m_press++;
`endif
    rst_n = 1'b0;
    wait_cycles(2);
    check_output("midreset value0", int'(bus0.o_value), 0);
    check_output("midreset value1", int'(bus1.o_value), 254);
    check_output("midreset pb_level", int'(bus0.o_pb_level), 0);
    pin_a  = 1'b0;
    pin_b  = 1'b0;
    pin_pb = 1'b0;
    model_reset();
    wait_cycles(8);
    rst_n = 1'b1;
    base_press = mon_press;
    base_long  = mon_long;
    base_up    = mon_up;
    base_dn    = mon_dn;
    wait_cycles(20);
    check_output("after reset press", mon_press - base_press, 0);
    check_output("after reset long", mon_long - base_long, 0);
    check_output("after reset steps", (mon_up - base_up) + (mon_dn - base_dn), 0);
    check_output("after reset press total", mon_press, m_press);

    // Randomized encoder turns, biased towards legal moves.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) nxt = order[(quad_pos(m_ab) + 1) % 4];
      else if (r < 9) nxt = order[(quad_pos(m_ab) + 3) % 4];
      else nxt = 2'($urandom_range(0, 3));
      hold = $urandom_range(9, 16);
      apply_stimulus(nxt, hold);
      check_model($sformatf("rand%0d", i));
    end

    // Return to the detent before random button presses.
    while (m_ab != 2'b00) apply_stimulus(order[(quad_pos(m_ab) + 1) % 4], 10);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) held = $urandom_range(60, 90);
      else held = $urandom_range(10, 40);
      press_button($sformatf("rand press%0d", i), held);
    end

    check_output("up and dn together", mon_both, 0);
    check_model("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
